csr_trap_ctrl: RTL
==================

# csr_trap_ctrl

Machine-mode CSR file and trap sequencer for the RV64 core. Owns the `csr_regs_t` state, services CSR read/modify/write requests from the execute stage, and sequences trap entry (exception or timer interrupt) and `mret` return, driving a pipeline redirect. Sits beside the commit stage; the only writer of the machine CSRs.

## Interface
- `MXLEN`, 64: register width, from `common`.
- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `csr_raddr`  in  12  CSR read address.
- `csr_rdata`  out  64  combinational read data.
- `csr_wvalid`  in  1  CSR write request.
- `csr_waddr`  in  12  write address.
- `csr_wop`  in  2  01=write, 10=set, 11=clear; 00=no-op.
- `csr_wdata`  in  64  write/mask operand.
- `exc_valid`  in  1  committed instruction raised an exception.
- `exc_cause`  in  63  exception code.
- `exc_pc`, `exc_tval`  in  64  faulting pc / trap value.
- `mret_valid`  in  1  committed `mret`.
- `int_pc`  in  64  pc of next uncommitted instruction (interrupt return point).
- `int_ok`  in  1  pipeline at an interruptible boundary.
- `irq_timer`  in  1  machine timer interrupt line (level).
- `busy`  out  1  sequencer not IDLE; upstream stalls commit.
- `redirect_valid`  out  1  one-cycle pulse.
- `redirect_pc`  out  64  redirect target.

## Operation
- FSM: IDLE, SAVE, REDIRECT. Reset: IDLE, all CSRs 0 except `mstatus.mpp`=2'b11; `busy`=0, `redirect_valid`=0, `redirect_pc`=0.
- IDLE event priority (same cycle): exception > interrupt > `mret` > CSR write. Lower-priority events that cycle are dropped; upstream guarantees they are squashed.
- Interrupt pending = `mstatus.mie` & `mie[7]` & `mip[7]` & `int_ok` & no exception.
- Exception/interrupt: latch cause (interrupt: bit63=1, code 7), epc (`exc_pc` / `int_pc`), tval (`exc_tval` / 0); IDLE->SAVE.
- SAVE: `mepc`<=epc with bits[1:0] cleared, `mcause`, `mtval` written; `mstatus.mpie`<=`mie`, `mie`<=0, `mpp`<=2'b11. ->REDIRECT.
- REDIRECT: `redirect_valid`=1; target = `mtvec` base ({mtvec[63:2],2'b00}); if `mtvec[1:0]`==01 and cause is interrupt, base + 4*code (64-bit, wraps). ->IDLE.
- `mret` in IDLE: `mstatus.mie`<=`mpie`, `mpie`<=1, `mpp`<=2'b11; ->REDIRECT with target `mepc`.
- CSR write (IDLE only): new = wdata / old|wdata / old&~wdata. `mhartid` and `mip` read-only (writes ignored); `mip[7]` mirrors `irq_timer` registered each cycle. Unknown addresses: read 0, write ignored.
- `mcycle` increments every cycle (wraps at 2^64); a CSR write to `mcycle` that cycle wins over the increment.
- `csr_rdata` reflects register state, not the same-cycle write.

## Timing
- Trap: event cycle T (IDLE), CSRs updated at end of T+1 (SAVE), `redirect_valid` during T+2, IDLE at T+3. `busy` high T+1..T+2.
- `mret`: event at T, `mstatus` updated end of T, `redirect_valid` during T+1.
- CSR write visible on `csr_rdata` at T+1.
- Events arriving while `busy` are ignored.
- `resetn` low mid-sequence: immediate return to reset state, no redirect pulse.

## Structure
- Add to `csr_pkg`: `csr_wop_t` enum, `trap_state_t` enum, `MCAUSE_MTI` constant (bit63|7), `MTVEC_MODE_VECTORED`.
- Reuses `mstatus_t`, `csr_regs_t` and existing CSR address parameters.
- One sub-module natural: `csr_trap_fsm` (state, latched cause/epc/tval, redirect generation); CSR storage stays in the top.

## Test plan
- Reset: release `resetn` -> all CSRs 0, `mstatus.mpp`=3, `mcycle` reads 1 one cycle later; no redirect.
- CSR ops: write `mtvec`=0x8000_0100, set 0x1, clear 0x100 -> reads 0x8000_0100, 0x8000_0101, 0x8000_0001.
- Exception: `mtvec`=0x8000_0000, `exc_cause`=2, `exc_pc`=0x8000_1002, tval=0xdead -> redirect 0x8000_0000 at T+2; `mepc`=0x8000_1000, `mcause`=2, `mtval`=0xdead, `mstatus.mie`=0.
- Vectored timer interrupt: `mtvec`=0x8000_0001, `mstatus.mie`=1, `mie[7]`=1, `irq_timer`=1, `int_ok`=1 -> redirect 0x8000_001c, `mcause`=0x8000_0000_0000_0007.
- Priority: exception and `mret` and CSR write same cycle -> only trap taken, CSR unchanged; then `mret` -> redirect to `mepc`, `mstatus.mie` restored.
- Reset asserted in SAVE -> no redirect, CSRs at reset values; `mcycle` write 0xffff_ffff_ffff_ffff -> wraps to 0 next cycle.

Source files
------------

// File: rtl/csr_pkg.sv
// Machine-mode CSR types, addresses and helpers shared by the
// trap controller, its sequencer and the execute/commit stages.
package csr_pkg;

  localparam int MXLEN = 64;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [MXLEN-1:0] MCAUSE_MTI = {1'b1, 63'd7};
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  typedef enum logic [1:0] {
    WOP_NOP   = 2'b00,
    WOP_WRITE = 2'b01,
    WOP_SET   = 2'b10,
    WOP_CLEAR = 2'b11
  } csr_wop_t;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_SAVE,
    TS_REDIRECT
  } trap_state_t;

  typedef struct packed {
    logic [63:13] rsv3;
    logic [1:0]   mpp;
    logic [10:8]  rsv2;
    logic         mpie;
    logic [6:4]   rsv1;
    logic         mie;
    logic [2:0]   rsv0;
  } mstatus_t;

  typedef struct packed {
    mstatus_t         mstatus;
    logic [MXLEN-1:0] mie;
    logic [MXLEN-1:0] mtvec;
    logic [MXLEN-1:0] mscratch;
    logic [MXLEN-1:0] mepc;
    logic [MXLEN-1:0] mcause;
    logic [MXLEN-1:0] mtval;
    logic [MXLEN-1:0] mip;
    logic [MXLEN-1:0] mcycle;
    logic [MXLEN-1:0] mhartid;
  } csr_regs_t;

  function automatic csr_regs_t csr_reset();
    csr_regs_t r;
    r = '0;
    r.mstatus.mpp = PRV_M;
    return r;
  endfunction

  function automatic logic [MXLEN-1:0] csr_read(
    input csr_regs_t r,
    input logic [11:0] a
  );
    logic [MXLEN-1:0] d;
    d = '0;
    case (a)
      CSR_MSTATUS:  d = r.mstatus;
      CSR_MIE:      d = r.mie;
      CSR_MTVEC:    d = r.mtvec;
      CSR_MSCRATCH: d = r.mscratch;
      CSR_MEPC:     d = r.mepc;
      CSR_MCAUSE:   d = r.mcause;
      CSR_MTVAL:    d = r.mtval;
      CSR_MIP:      d = r.mip;
      CSR_MCYCLE:   d = r.mcycle;
      CSR_MHARTID:  d = r.mhartid;
      default:      d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [MXLEN-1:0] csr_apply(
    input csr_wop_t op,
    input logic [MXLEN-1:0] old,
    input logic [MXLEN-1:0] wd
  );
    logic [MXLEN-1:0] n;
    n = old;
    case (op)
      WOP_WRITE: n = wd;
      WOP_SET:   n = old | wd;
      WOP_CLEAR: n = old & ~wd;
      default:   n = old;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// CSR access, commit-event and redirect bundle between the
// execute/commit stages and the trap controller.
interface csr_trap_ctrl_if;
  import csr_pkg::*;

  logic [11:0]      csr_raddr;
  logic [MXLEN-1:0] csr_rdata;
  logic             csr_wvalid;
  logic [11:0]      csr_waddr;
  csr_wop_t         csr_wop;
  logic [MXLEN-1:0] csr_wdata;
  logic             exc_valid;
  logic [62:0]      exc_cause;
  logic [MXLEN-1:0] exc_pc;
  logic [MXLEN-1:0] exc_tval;
  logic             mret_valid;
  logic [MXLEN-1:0] int_pc;
  logic             int_ok;
  logic             irq_timer;
  logic             busy;
  logic             redirect_valid;
  logic [MXLEN-1:0] redirect_pc;

  modport master (
    output csr_raddr, csr_wvalid, csr_waddr, csr_wop, csr_wdata,
    output exc_valid, exc_cause, exc_pc, exc_tval,
    output mret_valid, int_pc, int_ok, irq_timer,
    input  csr_rdata, busy, redirect_valid, redirect_pc
  );

  modport slave (
    input  csr_raddr, csr_wvalid, csr_waddr, csr_wop, csr_wdata,
    input  exc_valid, exc_cause, exc_pc, exc_tval,
    input  mret_valid, int_pc, int_ok, irq_timer,
    output csr_rdata, busy, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_trap_fsm.sv
// Trap sequencer: IDLE/SAVE/REDIRECT, latches cause, epc and tval
// and generates the redirect pulse and target.
module csr_trap_fsm
  import csr_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_exc_valid,
  input  logic [62:0]      i_exc_cause,
  input  logic [MXLEN-1:0] i_exc_pc,
  input  logic [MXLEN-1:0] i_exc_tval,
  input  logic             i_int_pend,
  input  logic [MXLEN-1:0] i_int_pc,
  input  logic             i_mret_valid,
  input  logic [MXLEN-1:0] i_mtvec,
  input  logic [MXLEN-1:0] i_mepc,
  output logic             o_idle,
  output logic             o_save,
  output logic             o_mret_take,
  output logic             o_busy,
  output logic             o_redirect_valid,
  output logic [MXLEN-1:0] o_redirect_pc,
  output logic [MXLEN-1:0] o_cause,
  output logic [MXLEN-1:0] o_epc,
  output logic [MXLEN-1:0] o_tval
);

  trap_state_t      r_state;
  trap_state_t      w_next;
  logic             w_trap;
  logic             w_mret;
  logic             r_is_mret;
  logic [MXLEN-1:0] r_cause;
  logic [MXLEN-1:0] r_epc;
  logic [MXLEN-1:0] r_tval;
  logic [MXLEN-1:0] w_base;
  logic [MXLEN-1:0] w_target;
  logic             w_vec;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= TS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_trap = 1'b0;
    w_mret = 1'b0;
    unique case (r_state)
      TS_IDLE: begin
        if (i_exc_valid || i_int_pend) begin
          w_trap = 1'b1;
          w_next = TS_SAVE;
        end else if (i_mret_valid) begin
          w_mret = 1'b1;
          w_next = TS_REDIRECT;
        end
      end
      TS_SAVE:     w_next = TS_REDIRECT;
      TS_REDIRECT: w_next = TS_IDLE;
      default:     w_next = TS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cause   <= '0;
      r_epc     <= '0;
      r_tval    <= '0;
      r_is_mret <= 1'b0;
    end else if (w_trap) begin
      r_cause   <= i_exc_valid ? {1'b0, i_exc_cause} : MCAUSE_MTI;
      r_epc     <= i_exc_valid ? i_exc_pc : i_int_pc;
      r_tval    <= i_exc_valid ? i_exc_tval : '0;
      r_is_mret <= 1'b0;
    end else if (w_mret) begin
      r_is_mret <= 1'b1;
    end
  end

  // vectored mode only offsets interrupts; exceptions use the base
  assign w_base   = {i_mtvec[MXLEN-1:2], 2'b00};
  assign w_vec    = (i_mtvec[1:0] == MTVEC_MODE_VECTORED) && r_cause[MXLEN-1];
  assign w_target = w_base + (w_vec ? {r_cause[MXLEN-3:0], 2'b00} : '0);

  assign o_idle           = (r_state == TS_IDLE);
  assign o_save           = (r_state == TS_SAVE);
  assign o_mret_take      = w_mret;
  assign o_busy           = (r_state != TS_IDLE);
  assign o_redirect_valid = (r_state == TS_REDIRECT);
  assign o_redirect_pc    = (r_state == TS_REDIRECT)
                          ? (r_is_mret ? i_mepc : w_target) : '0;
  assign o_cause          = r_cause;
  assign o_epc            = r_epc;
  assign o_tval           = r_tval;

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file; sole writer of the machine CSRs, with
// trap entry and mret sequenced by csr_trap_fsm.
module csr_trap_ctrl
  import csr_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  csr_trap_ctrl_if.slave bus
);

  csr_regs_t        r_csr;
  logic             w_idle;
  logic             w_save;
  logic             w_mret_take;
  logic             w_int_pend;
  logic             w_csr_take;
  logic [MXLEN-1:0] w_old;
  logic [MXLEN-1:0] w_new;
  logic [MXLEN-1:0] w_cause;
  logic [MXLEN-1:0] w_epc;
  logic [MXLEN-1:0] w_tval;

  assign w_int_pend = r_csr.mstatus.mie & r_csr.mie[7] & r_csr.mip[7]
                    & bus.int_ok & ~bus.exc_valid;

  // a write only lands when nothing higher-priority fires this cycle
  assign w_csr_take = w_idle & bus.csr_wvalid
                    & (bus.csr_wop != WOP_NOP)
                    & ~bus.exc_valid & ~w_int_pend & ~bus.mret_valid;

  assign w_old = csr_read(r_csr, bus.csr_waddr);
  assign w_new = csr_apply(bus.csr_wop, w_old, bus.csr_wdata);

  assign bus.csr_rdata = csr_read(r_csr, bus.csr_raddr);

  csr_trap_fsm u_fsm (
    .clk              (clk),
    .resetn           (resetn),
    .i_exc_valid      (bus.exc_valid),
    .i_exc_cause      (bus.exc_cause),
    .i_exc_pc         (bus.exc_pc),
    .i_exc_tval       (bus.exc_tval),
    .i_int_pend       (w_int_pend),
    .i_int_pc         (bus.int_pc),
    .i_mret_valid     (bus.mret_valid),
    .i_mtvec          (r_csr.mtvec),
    .i_mepc           (r_csr.mepc),
    .o_idle           (w_idle),
    .o_save           (w_save),
    .o_mret_take      (w_mret_take),
    .o_busy           (bus.busy),
    .o_redirect_valid (bus.redirect_valid),
    .o_redirect_pc    (bus.redirect_pc),
    .o_cause          (w_cause),
    .o_epc            (w_epc),
    .o_tval           (w_tval)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_csr <= csr_reset();
    end else begin
      r_csr.mcycle <= r_csr.mcycle + 64'd1;
      r_csr.mip    <= {56'd0, bus.irq_timer, 7'd0};
      if (w_save) begin
        r_csr.mepc         <= {w_epc[MXLEN-1:2], 2'b00};
        r_csr.mcause       <= w_cause;
        r_csr.mtval        <= w_tval;
        r_csr.mstatus.mpie <= r_csr.mstatus.mie;
        r_csr.mstatus.mie  <= 1'b0;
        r_csr.mstatus.mpp  <= PRV_M;
      end else if (w_mret_take) begin
        r_csr.mstatus.mie  <= r_csr.mstatus.mpie;
        r_csr.mstatus.mpie <= 1'b1;
        r_csr.mstatus.mpp  <= PRV_M;
      end else if (w_csr_take) begin
        // mhartid, mip and unmapped addresses fall to the default
        case (bus.csr_waddr)
          CSR_MSTATUS:  r_csr.mstatus  <= mstatus_t'(w_new);
          CSR_MIE:      r_csr.mie      <= w_new;
          CSR_MTVEC:    r_csr.mtvec    <= w_new;
          CSR_MSCRATCH: r_csr.mscratch <= w_new;
          CSR_MEPC:     r_csr.mepc     <= w_new;
          CSR_MCAUSE:   r_csr.mcause   <= w_new;
          CSR_MTVAL:    r_csr.mtval    <= w_new;
          CSR_MCYCLE:   r_csr.mcycle   <= w_new;
          default:      ;
        endcase
      end
    end
  end

endmodule
